grid_access_arbiter: RTL and testbench

Shares the single read port of the maze grid BRAM between the movement controller (wall check on a step) and the raycaster DDA (cell lookups per ray). Each requester uses a req/addr → valid/data handshake. The arbiter grants one requester at a time with round-robin fairness and drives the BRAM address. It returns the cell value with a one-cycle valid pulse to the granted requester only.

---
 rtl/grid_access_arbiter_pkg.sv | 18 +
 rtl/grid_access_arbiter_if.sv | 30 +++
 rtl/grid_access_arbiter_rr_arbiter_2.sv | 24 ++
 rtl/grid_access_arbiter.sv | 131 +++++++++++++
 tb/tb_grid_access_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/grid_access_arbiter_pkg.sv
// Shared maze-grid definitions: grid geometry, cell encodings and the
// state type of the grid read-port arbiter.
package grid_pkg;

  localparam int GRID_N      = 24;
  localparam int GRID_ADDR_W = $clog2(GRID_N * GRID_N);
  localparam int CELL_W      = 5;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 5'd0;
  localparam logic [CELL_W-1:0] CELL_OOB   = 5'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/grid_access_arbiter_if.sv
// Request/response bundle between the two grid requesters, the arbiter and
// the grid BRAM read port.
interface grid_access_arbiter_if
  import grid_pkg::*;
#(
  parameter int ADDR_W = GRID_ADDR_W,
  parameter int DATA_W = CELL_W
);
  logic              mv_req;
  logic [ADDR_W-1:0] mv_addr;
  logic              mv_valid;
  logic [DATA_W-1:0] mv_data;
  logic              rc_req;
  logic [ADDR_W-1:0] rc_addr;
  logic              rc_valid;
  logic [DATA_W-1:0] rc_data;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_douta;
  logic              busy;

  modport master (
    output mv_req, mv_addr, rc_req, rc_addr, bram_douta,
    input  mv_valid, mv_data, rc_valid, rc_data, bram_addra, busy
  );

  modport slave (
    input  mv_req, mv_addr, rc_req, rc_addr, bram_douta,
    output mv_valid, mv_data, rc_valid, rc_data, bram_addra, busy
  );
endinterface

// File: rtl/grid_access_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin select; owner 0 = movement, 1 = raycaster.
// The last_grant state is kept by the caller.
module rr_arbiter_2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant,
  output logic owner
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req_a | req_b;
    owner = 1'b0;
    if (req_a && req_b) begin
      owner = ~last_grant;
    end else if (req_b) begin
      owner = 1'b1;
    end else begin
      owner = 1'b0;
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Shares the grid BRAM read port between movement and raycaster requesters,
// returning each lookup with a one-cycle valid pulse to its owner.
module grid_access_arbiter
  import grid_pkg::*;
#(
  parameter int                N            = GRID_N,
  parameter int                ADDR_W       = $clog2(N * N),
  parameter int                DATA_W       = CELL_W,
  parameter int                READ_LATENCY = 2,
  parameter logic [DATA_W-1:0] OOB_VALUE    = DATA_W'(CELL_OOB)
) (
  input logic           clk_in,
  input logic           rst_in,
  grid_access_arbiter_if.slave bus
);

  localparam int              CELLS    = N * N;
  localparam int              CNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);

  arb_state_t        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              owner_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addra_r;
  logic [DATA_W-1:0] mv_data_r;
  logic [DATA_W-1:0] rc_data_r;
  logic              mv_valid_r;
  logic              rc_valid_r;
  logic              busy_r;

  logic              grant_s;
  logic              owner_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              in_range_s;

  rr_arbiter_2 u_rr (
    .req_a      (bus.mv_req),
    .req_b      (bus.rc_req),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .owner      (owner_s)
  );

  // Address of the requester that would win this cycle, and its range check.
  always_comb begin
    sel_addr_s = bus.mv_addr;
    if (owner_s) begin
      sel_addr_s = bus.rc_addr;
    end else begin
      sel_addr_s = bus.mv_addr;
    end
    in_range_s = (32'(sel_addr_s) < 32'(CELLS));
  end

  // Grant / wait / respond state machine with all outputs registered.
  // douta for the address launched at the grant edge is sampled
  // READ_LATENCY+1 edges later, so the counter runs down to zero in WAIT.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      addra_r      <= '0;
      mv_data_r    <= '0;
      rc_data_r    <= '0;
      mv_valid_r   <= 1'b0;
      rc_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      mv_valid_r <= 1'b0;
      rc_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r      <= owner_s;
            last_grant_r <= owner_s;
            busy_r       <= 1'b1;
            if (in_range_s) begin
              addra_r <= sel_addr_s;
              cnt_r   <= CNT_LOAD;
              state_r <= WAIT;
            end else begin
              if (owner_s) begin
                rc_data_r  <= OOB_VALUE;
                rc_valid_r <= 1'b1;
              end else begin
                mv_data_r  <= OOB_VALUE;
                mv_valid_r <= 1'b1;
              end
              state_r <= DONE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == '0) begin
            if (owner_r) begin
              rc_data_r  <= bus.bram_douta;
              rc_valid_r <= 1'b1;
            end else begin
              mv_data_r  <= bus.bram_douta;
              mv_valid_r <= 1'b1;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bram_addra = addra_r;
  assign bus.mv_valid   = mv_valid_r;
  assign bus.mv_data    = mv_data_r;
  assign bus.rc_valid   = rc_valid_r;
  assign bus.rc_data    = rc_data_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Scoreboard bench for grid_access_arbiter: stimulus queues expected
// responses per requester, a negedge monitor pops and compares them.
module tb_grid_access_arbiter;
  import grid_pkg::*;

  localparam int N      = 24;
  localparam int AW     = 10;
  localparam int DW     = 5;
  localparam int RL     = 2;
  localparam int LAT_IN = RL + 1;          // grant edge to valid, in edges
  localparam int LAT_TIE = 2 * LAT_IN + 2; // loser of a tie

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  grid_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  grid_access_arbiter #(
    .N(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .OOB_VALUE(5'd1)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Two-stage synchronous BRAM model: douta follows addra after RL edges.
  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] addr_q;
  always @(posedge clk_in) begin
    addr_q         <= bus.bram_addra;
    bus.bram_douta <= mem[addr_q];
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t mv_q[$];
  exp_t rc_q[$];

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every valid pulse must match the head of its requester's queue.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      if (bus.mv_valid || bus.rc_valid)
        check("one_valid_at_a_time", int'(bus.mv_valid & bus.rc_valid), 0);
      if (bus.mv_valid) begin
        check("mv_valid_expected", int'(mv_q.size() != 0), 1);
        if (mv_q.size() != 0) begin
          e = mv_q.pop_front();
          check("mv_data", int'(bus.mv_data), int'(e.data));
          if (e.cyc >= 0) check("mv_valid_cycle", cyc, e.cyc);
        end
      end
      if (bus.rc_valid) begin
        check("rc_valid_expected", int'(rc_q.size() != 0), 1);
        if (rc_q.size() != 0) begin
          e = rc_q.pop_front();
          check("rc_data", int'(bus.rc_data), int'(e.data));
          if (e.cyc >= 0) check("rc_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One requester transaction; lat < 0 means arrival cycle is not checked.
  task automatic do_req(input bit who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lat, input bit chk_addr, input logic [AW-1:0] exp_addra,
                        output int waited);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk_in);
    e.data = d;
    e.cyc  = (lat < 0) ? -1 : cyc + 1 + lat;
    if (who) begin
      rc_q.push_back(e);
      bus.rc_req  = 1'b1;
      bus.rc_addr = a;
    end else begin
      mv_q.push_back(e);
      bus.mv_req  = 1'b1;
      bus.mv_addr = a;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk_in);
      n++;
      if (n == 1 && chk_addr) begin
        check("bram_addra_after_grant", int'(bus.bram_addra), int'(exp_addra));
        check("busy_after_grant", int'(bus.busy), 1);
      end
      got = who ? bus.rc_valid : bus.mv_valid;
    end
    check(who ? "rc_valid_within_budget" : "mv_valid_within_budget", int'(got), 1);
    waited = n;
    if (who) bus.rc_req = 1'b0;
    else     bus.mv_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  int w_mv, w_rc;

  initial begin
    bus.mv_req  = 1'b0;
    bus.mv_addr = 10'd0;
    bus.rc_req  = 1'b0;
    bus.rc_addr = 10'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 5'((i * 3) % 32);
    mem[25] = 5'd0;
    mem[10] = 5'd3;
    mem[11] = 5'd0;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_mv_valid", int'(bus.mv_valid), 0);
    check("rst_rc_valid", int'(bus.rc_valid), 0);
    check("rst_bram_addra", int'(bus.bram_addra), 0);
    check("rst_mv_data", int'(bus.mv_data), 0);
    check("rst_rc_data", int'(bus.rc_data), 0);
    rst_in = 1'b0;

    // Single movement lookup, cell 25 holds 0
    do_req(1'b0, 10'd25, 5'd0, LAT_IN, 1'b1, 10'd25, w_mv);
    repeat (4) @(negedge clk_in);
    check("idle_after_single", int'(bus.busy), 0);

    // Tie straight after reset: movement first, raycaster next
    do_reset();
    fork
      do_req(1'b0, 10'd10, 5'd3, LAT_IN,  1'b1, 10'd10, w_mv);
      do_req(1'b1, 10'd11, 5'd0, LAT_TIE, 1'b0, 10'd0,  w_rc);
    join
    // Lone movement lookup (cell 12 = 36 mod 32 = 4), then a tie goes to rc
    do_req(1'b0, 10'd12, 5'd4, LAT_IN, 1'b1, 10'd12, w_mv);
    fork
      do_req(1'b1, 10'd11, 5'd0, LAT_IN,  1'b1, 10'd11, w_rc);
      do_req(1'b0, 10'd10, 5'd3, LAT_TIE, 1'b0, 10'd0,  w_mv);
    join

    // Out-of-range raycaster address: immediate wall value, address untouched
    do_req(1'b1, 10'd576, 5'd1, 0, 1'b1, 10'd10, w_rc);
    @(negedge clk_in);
    check("oob_addra_held", int'(bus.bram_addra), 10);

    // Raycaster stream with a movement request arriving mid-stream
    fork
      begin
        for (int i = 0; i < 30; i++)
          do_req(1'b1, 10'(200 + i), 5'(((200 + i) * 3) % 32), -1, 1'b0, 10'd0, w_rc);
      end
      begin
        repeat (40) @(negedge clk_in);
        do_req(1'b0, 10'd300, 5'd4, -1, 1'b0, 10'd0, w_mv);
        check("mv_wait_le_8", int'(w_mv <= 8), 1);
      end
    join
    repeat (3) @(negedge clk_in);

    // Reset during WAIT aborts the lookup; next lookup has normal latency
    @(negedge clk_in);
    bus.mv_req  = 1'b1;
    bus.mv_addr = 10'd50;
    @(negedge clk_in);
    check("busy_in_wait", int'(bus.busy), 1);
    #2 rst_in = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_mv_valid", int'(bus.mv_valid), 0);
    check("abort_rc_valid", int'(bus.rc_valid), 0);
    check("abort_addra", int'(bus.bram_addra), 0);
    bus.mv_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    do_req(1'b0, 10'd50, 5'd22, LAT_IN, 1'b1, 10'd50, w_mv);

    // Movement drops req during WAIT: one pulse, no re-grant (cell 60 = 20)
    @(negedge clk_in);
    mv_q.push_back('{data: 5'd20, cyc: cyc + 1 + LAT_IN});
    bus.mv_req  = 1'b1;
    bus.mv_addr = 10'd60;
    @(negedge clk_in);
    bus.mv_req = 1'b0;
    repeat (8) @(negedge clk_in);
    check("no_regrant_busy", int'(bus.busy), 0);
    check("drop_pulse_seen", mv_q.size(), 0);

    repeat (3) @(negedge clk_in);
    check("mv_queue_drained", mv_q.size(), 0);
    check("rc_queue_drained", rc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
